// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmitter/receiver pair.
package i2s_pkg;
    localparam int I2S_WIDTH_DEFAULT = 16;

    typedef logic [I2S_WIDTH_DEFAULT-1:0] i2s_sample_t;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;
endpackage

// File: rtl/i2s_transceiver_rx.sv
// I2S slave receiver: no slot counter, a word completes on every ws edge
// and holds the last WIDTH bits shifted in, current sample included.
module I2Srx
    import i2s_pkg::*;
#(
    parameter int WIDTH = I2S_WIDTH_DEFAULT
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             ws_i,
    input  logic             sdata_i,
    output logic [WIDTH-1:0] left_rx_chan,
    output logic [WIDTH-1:0] right_rx_chan,
    output logic             pktI2SRxChanged_o
);
    logic [WIDTH-1:0] r_shift;
    logic             r_ws_d;
    logic [WIDTH-1:0] w_word;

    assign w_word = {r_shift[WIDTH-2:0], sdata_i};

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_shift           <= '0;
            r_ws_d            <= LEFT;
            left_rx_chan      <= '0;
            right_rx_chan     <= '0;
            pktI2SRxChanged_o <= 1'b0;
        end else begin
            r_shift           <= w_word;
            r_ws_d            <= ws_i;
            pktI2SRxChanged_o <= 1'b0;
            if (ws_i != r_ws_d) begin
                if (r_ws_d == LEFT) begin
                    left_rx_chan <= w_word;
                end else begin
                    right_rx_chan     <= w_word;
                    pktI2SRxChanged_o <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/i2s_transceiver_tx.sv
// I2S master transmitter: frame counter drives ws, one shift register
// serialises left then right, MSB first, with the standard one-bit delay.
module I2Stx
    import i2s_pkg::*;
#(
    parameter int WIDTH = I2S_WIDTH_DEFAULT
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] left_tx_chan,
    input  logic [WIDTH-1:0] right_tx_chan,
    output logic             ws_o,
    output logic             sdata_o
);
    localparam int CW = $clog2(2 * WIDTH);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             w_start_left;
    logic             w_start_right;

    // Edges that begin slot 0 and slot W respectively.
    assign w_start_left  = (r_cnt == CW'(2 * WIDTH - 1));
    assign w_start_right = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            ws_o    <= LEFT;
            sdata_o <= 1'b0;
        end else begin
            r_cnt <= w_start_left ? '0 : r_cnt + 1'b1;
            if (w_start_right)
                ws_o <= RIGHT;
            else if (w_start_left)
                ws_o <= LEFT;
            // The bit leaving the shifter is always one slot behind the load,
            // which yields the one-bit delay relative to ws.
            sdata_o <= r_shift[WIDTH-1];
        end
    end

    // Loading left while in reset makes the reset state act as slot 0.
    always_ff @(posedge sclk) begin
        if (!rst || w_start_left)
            r_shift <= left_tx_chan;
        else if (w_start_right)
            r_shift <= right_tx_chan;
        else
            r_shift <= r_shift << 1;
    end
endmodule

// File: rtl/i2s_transceiver.sv
// I2S stereo link top: independent master tx and slave rx sharing clock/reset.
module i2s_transceiver
    import i2s_pkg::*;
#(
    parameter int WIDTH = I2S_WIDTH_DEFAULT
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] left_tx_chan,
    input  logic [WIDTH-1:0] right_tx_chan,
    output logic             ws_o,
    output logic             sdata_o,
    input  logic             ws_i,
    input  logic             sdata_i,
    output logic [WIDTH-1:0] left_rx_chan,
    output logic [WIDTH-1:0] right_rx_chan,
    output logic             pktI2SRxChanged_o
);
    I2Stx #(.WIDTH(WIDTH)) u_tx (
        .sclk          (sclk),
        .rst           (rst),
        .left_tx_chan  (left_tx_chan),
        .right_tx_chan (right_tx_chan),
        .ws_o          (ws_o),
        .sdata_o       (sdata_o)
    );

    I2Srx #(.WIDTH(WIDTH)) u_rx (
        .sclk              (sclk),
        .rst               (rst),
        .ws_i              (ws_i),
        .sdata_i           (sdata_i),
        .left_rx_chan      (left_rx_chan),
        .right_rx_chan     (right_rx_chan),
        .pktI2SRxChanged_o (pktI2SRxChanged_o)
    );
endmodule

// File: tb/tb_i2s_transceiver.sv
// Bench for i2s_transceiver: loopback frames checked slot by slot against a
// frame-level model, plus a directly driven rx with irregular slot lengths.
module tb_i2s_transceiver;
    localparam int W = 16;
    localparam int P = 2 * W;

    logic         sclk = 1'b0;
    logic         rst;
    logic [W-1:0] left_tx, right_tx;
    logic         ws_o, sdata_o, ws_i, sdata_i;
    logic [W-1:0] left_rx, right_rx;
    logic         stb;
    logic         loop;
    logic         tb_ws, tb_sd;

    assign ws_i    = loop ? ws_o    : tb_ws;
    assign sdata_i = loop ? sdata_o : tb_sd;

    i2s_transceiver #(.WIDTH(W)) dut (
        .sclk              (sclk),
        .rst               (rst),
        .left_tx_chan      (left_tx),
        .right_tx_chan     (right_tx),
        .ws_o              (ws_o),
        .sdata_o           (sdata_o),
        .ws_i              (ws_i),
        .sdata_i           (sdata_i),
        .left_rx_chan      (left_rx),
        .right_rx_chan     (right_rx),
        .pktI2SRxChanged_o (stb)
    );

    always #5 sclk = ~sclk;

    int           checks = 0;
    int           errors = 0;
    int           t;                 // rising edges since reset release
    logic [W-1:0] Lf [0:127];        // left word each frame carries
    logic [W-1:0] Rf [0:127];
    logic [W-1:0] exp_l, exp_r;
    logic [63:0]  hist;              // serial stream seen by rx, newest in bit 0
    logic         pws;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ws"},    32'(ws_o),     32'h0);
        chk({tag, "_sd"},    32'(sdata_o),  32'h0);
        chk({tag, "_left"},  32'(left_rx),  32'h0);
        chk({tag, "_right"}, 32'(right_rx), 32'h0);
        chk({tag, "_stb"},   32'(stb),      32'h0);
    endtask

    // Called after a negedge; leaves the bench after the next negedge.
    task automatic rst_phase(input int n, input bit chk_now);
        rst = 1'b0;
        if (chk_now) begin
            #1;
            chk_zero("rst_async");
        end
        for (int i = 0; i < n; i++) begin
            @(posedge sclk);
            #1;
            chk_zero("rst_hold");
            @(negedge sclk);
        end
        rst   = 1'b1;
        t     = 0;
        Lf[0] = left_tx;
        exp_l = '0;
        exp_r = '0;
        hist  = '0;
        pws   = 1'b0;
    endtask

    task automatic check_loop();
        int  k, f;
        logic es, esd;
        k   = t % P;
        f   = t / P;
        esd = 1'b0;
        if (k >= 1 && k <= W)  esd = Lf[f][W-k];
        else if (k > W)        esd = Rf[f][P-k];
        else if (f > 0)        esd = Rf[f-1][0];
        es = 1'b0;
        if (k == W + 1) exp_l = Lf[f];
        if (k == 1 && f > 0) begin
            exp_r = Rf[f-1];
            es    = 1'b1;
        end
        chk("tx_ws",    32'(ws_o),     32'(k >= W));
        chk("tx_sd",    32'(sdata_o),  32'(esd));
        chk("rx_left",  32'(left_rx),  32'(exp_l));
        chk("rx_right", 32'(right_rx), 32'(exp_r));
        chk("rx_stb",   32'(stb),      32'(es));
    endtask

    task automatic cyc();
        int tn;
        tn = t + 1;
        if (tn % P == 0) Lf[tn/P] = left_tx;
        if (tn % P == W) Rf[tn/P] = right_tx;
        @(posedge sclk);
        t = tn;
        #1;
        check_loop();
        @(negedge sclk);
    endtask

    task automatic run_rand(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(7) == 0) left_tx  = W'($urandom);
            if ($urandom_range(7) == 0) right_tx = W'($urandom);
            cyc();
        end
    endtask

    task automatic run_to(input int target);
        while (t < target) cyc();
    endtask

    // Direct rx drive: expected word is the last W bits of the whole stream.
    task automatic drv(input logic w, input logic b);
        logic es;
        tb_ws = w;
        tb_sd = b;
        @(posedge sclk);
        #1;
        hist = {hist[62:0], b};
        es   = 1'b0;
        if (w != pws) begin
            if (pws == 1'b0) exp_l = hist[W-1:0];
            else begin
                exp_r = hist[W-1:0];
                es    = 1'b1;
            end
        end
        pws = w;
        chk("drx_left",  32'(left_rx),  32'(exp_l));
        chk("drx_right", 32'(right_rx), 32'(exp_r));
        chk("drx_stb",   32'(stb),      32'(es));
        @(negedge sclk);
    endtask

    task automatic slot(input logic w, input int n);
        for (int i = 0; i < n; i++) drv(w, 1'($urandom));
    endtask

    initial begin
        int fc;
        loop     = 1'b1;
        tb_ws    = 1'b0;
        tb_sd    = 1'b0;
        left_tx  = 16'hdead;
        right_tx = 16'hbeef;
        t        = 0;

        // Reset hold, then the basic dead/beef loopback frame.
        rst_phase(10, 1'b0);
        run_to(P + 1);
        chk("lb_left",  32'(left_rx),  32'h0000dead);
        chk("lb_right", 32'(right_rx), 32'h0000beef);

        // Bit order with single-bit words.
        left_tx  = 16'h8000;
        right_tx = 16'h0001;
        fc = t / P + 1;
        run_to(fc * P + W + 1);
        chk("bo_left", 32'(left_rx), 32'h00008000);
        run_to((fc + 1) * P + 1);
        chk("bo_right", 32'(right_rx), 32'h00000001);

        // Changing left mid-frame must not disturb the word in flight.
        left_tx = 16'h1234;
        fc = t / P + 1;
        run_to(fc * P + 5);
        left_tx = 16'h5678;
        run_to(fc * P + W + 1);
        chk("cap_cur", 32'(left_rx), 32'h00001234);
        run_to((fc + 1) * P + W + 1);
        chk("cap_next", 32'(left_rx), 32'h00005678);

        // Random words changing at arbitrary cycles.
        run_rand(18 * P);

        // Reset in slot 20, then the first full frame after release.
        while (t % P != 20) cyc();
        rst_phase(3, 1'b1);
        run_to(P + 1);
        chk("mr_left",  32'(left_rx),  32'(Lf[0]));
        chk("mr_right", 32'(right_rx), 32'(Rf[0]));
        run_rand(3 * P);

        // Rx driven directly with long, exact and short slots.
        loop = 1'b0;
        rst_phase(2, 1'b0);
        slot(1'b0, 19);
        slot(1'b1, 12);
        slot(1'b0, 16);
        slot(1'b1, 16);
        slot(1'b0, 21);
        slot(1'b1, 5);
        slot(1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
